nts_tx_dispatch: RTL and testbench

- Downstream consumer of the double-buffered Tx packet buffer's dispatch FIFO interface.
- Pulls completed packets word by word and presents them as a 64-bit valid/ready stream with byte-keep and last markers to the MAC Tx adapter.
- Releases the buffer after the last beat is accepted.
- Hides the buffer's fixed read latency with a small credit-controlled skid FIFO, so back-to-back words flow at one per cycle.

---
 rtl/nts_tx_dispatch_if.sv | 19 +
 rtl/nts_tx_dispatch.sv | 263 ++++++++++++++++++++++++++
 tb/tb_nts_tx_dispatch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_tx_dispatch_if.sv
// ---------------------------------------------------------------------------
// nts_tx_dispatch_if
// Byte-keep valid/ready stream from the Tx dispatcher to the MAC Tx adapter.
//   valid  : beat valid (driven by master)
//   ready  : beat accepted when valid && ready (driven by slave)
//   data   : 64-bit beat, packet byte 0 in bits [63:56]
//   keep   : MSB-aligned byte enables
//   last   : final beat of the packet
// ---------------------------------------------------------------------------
interface nts_tx_dispatch_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/nts_tx_dispatch.sv
// ---------------------------------------------------------------------------
// nts_tx_dispatch
// Pulls completed packets word by word out of the double-buffered Tx packet
// buffer and streams them to the MAC Tx adapter, then releases the buffer.
// The buffer's fixed read latency is hidden by a credit-controlled skid FIFO.
//
// Ports
//   i_clk, i_areset_n      : clock / async active-low reset
//   i_tx_packet_available  : buffer holds a complete packet
//   o_tx_packet_read       : one-cycle release pulse
//   i_tx_fifo_empty        : no more words for this packet (valid the cycle
//                            after each rd_en)
//   o_tx_fifo_rd_en        : fetch next word
//   i_tx_fifo_rd_data      : word data, READ_LATENCY cycles after rd_en
//   i_tx_bytes_last_word   : valid bytes in the final word (0 means 8)
//   io_mac_tx              : master side of the MAC stream interface
//   o_busy                 : FSM not idle
//   o_error                : sticky protocol error
//   o_stat_packets/beats   : statistics counters
//
// Optional feature: define NTS_TX_DISPATCH_COUNTERS_EN to enable the
// packet/beat counters; otherwise the stat outputs are tied to zero.
// ---------------------------------------------------------------------------
module nts_tx_dispatch #(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              i_tx_packet_available,
    output logic              o_tx_packet_read,
    input  logic              i_tx_fifo_empty,
    output logic              o_tx_fifo_rd_en,
    input  logic [63:0]       i_tx_fifo_rd_data,
    input  logic [3:0]        i_tx_bytes_last_word,
    nts_tx_dispatch_if.master io_mac_tx,
    output logic              o_busy,
    output logic              o_error,
    output logic [31:0]       o_stat_packets,
    output logic [31:0]       o_stat_beats
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("nts_tx_dispatch: READ_LATENCY must be in 1..4");
        end
        if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
            $error("nts_tx_dispatch: FIFO_DEPTH must be >= READ_LATENCY+2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_RELEASE,
        S_WAIT_CLEAR
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    w_rd_en;
    logic                    w_flush;
    logic                    w_zero_pkt;
    logic                    w_capture;
    logic                    w_credit_ok;

    // Tag pipe: one valid bit per outstanding read, aligned to rd_data.
    logic [READ_LATENCY-1:0] r_tag_vld;
    logic [READ_LATENCY-1:0] w_tag_last;
    logic                    w_tag_last0;

    logic [64:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [64:0]             w_head;
    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_overflow;
    logic                    w_wr;

    logic [3:0]              r_last_bytes;
    logic                    r_error;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Empty is resolved the cycle after a read, which is exactly when the
    // oldest stage of the tag pipe sees it; mark that tag last in place.
    assign w_tag_last0 = r_tag_vld[0] & i_tx_fifo_empty;

    generate
        if (READ_LATENCY > 1) begin : g_last_pipe
            logic [READ_LATENCY-1:1] r_tag_last;
            always_ff @(posedge i_clk or negedge i_areset_n) begin
                if (!i_areset_n) begin
                    r_tag_last <= '0;
                end else if (w_flush) begin
                    r_tag_last <= '0;
                end else begin
                    r_tag_last <= w_tag_last[READ_LATENCY-2:0];
                end
            end
            assign w_tag_last = {r_tag_last, w_tag_last0};
        end else begin : g_last_direct
            assign w_tag_last = w_tag_last0;
        end
    endgenerate

    // Credits count both buffered words and reads still in flight, so the
    // skid FIFO cannot overflow regardless of how long ready is held low.
    assign w_credit_ok = (int'(r_count) + $countones(r_tag_vld)) < FIFO_DEPTH;

    assign w_valid    = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_pop      = w_valid && io_mac_tx.ready;
    assign w_push     = r_tag_vld[READ_LATENCY-1];
    assign w_overflow = w_push && (r_count == CNT_W'(FIFO_DEPTH)) && !w_pop;
    assign w_wr       = w_push && !w_overflow;

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_flush      = 1'b0;
        w_zero_pkt   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_tx_packet_available) begin
                    w_capture = 1'b1;
                    if (i_tx_fifo_empty) begin
                        w_zero_pkt   = 1'b1;
                        w_state_next = S_RELEASE;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!i_tx_packet_available) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_tag_last0) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_rd_en = !i_tx_fifo_empty && w_credit_ok;
                end
            end
            S_DRAIN: begin
                if (!i_tx_packet_available) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_pop && w_head[0]) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                if (!i_tx_packet_available) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state      <= S_IDLE;
            r_tag_vld    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_bytes <= 4'd8;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_error <= r_error | w_zero_pkt | w_flush | w_overflow;
            if (w_capture) begin
                r_last_bytes <= (i_tx_bytes_last_word == 4'd0 || i_tx_bytes_last_word > 4'd8)
                                ? 4'd8 : i_tx_bytes_last_word;
            end
            if (w_flush) begin
                r_tag_vld <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
            end else begin
                for (int k = READ_LATENCY - 1; k > 0; k--) begin
                    r_tag_vld[k] <= r_tag_vld[k-1];
                end
                r_tag_vld[0] <= w_rd_en;
                if (w_wr) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_wr && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_wr && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; outputs are gated by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {i_tx_fifo_rd_data, w_tag_last[READ_LATENCY-1]};
        end
    end

    assign io_mac_tx.valid = w_valid;
    assign io_mac_tx.data  = w_valid ? w_head[64:1] : 64'd0;
    assign io_mac_tx.last  = w_valid && w_head[0];
    assign io_mac_tx.keep  = !w_valid ? 8'h00 :
                             w_head[0] ? (8'hFF << (4'd8 - r_last_bytes)) : 8'hFF;

    assign o_tx_fifo_rd_en  = w_rd_en;
    assign o_tx_packet_read = (r_state == S_RELEASE);
    assign o_busy           = (r_state != S_IDLE);
    assign o_error          = r_error;

`ifdef NTS_TX_DISPATCH_COUNTERS_EN
    logic [31:0] r_stat_packets;
    logic [31:0] r_stat_beats;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_stat_packets <= '0;
            r_stat_beats   <= '0;
        end else begin
            if (r_state == S_RELEASE) begin
                r_stat_packets <= r_stat_packets + 32'd1;
            end
            // A beat taken by the MAC counts even if the packet later aborts.
            if (w_pop) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
        end
    end

    assign o_stat_packets = r_stat_packets;
    assign o_stat_beats   = r_stat_beats;
`else
    assign o_stat_packets = 32'd0;
    assign o_stat_beats   = 32'd0;
`endif

endmodule

// File: tb/tb_nts_tx_dispatch.sv
module tb_nts_tx_dispatch;

    localparam int RL = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_avail;
    logic        pkt_read;
    logic        fifo_empty;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [3:0]  bytes_last;
    logic        busy;
    logic        error;
    logic [31:0] stat_p;
    logic [31:0] stat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nts_tx_dispatch_if mac_if ();

    nts_tx_dispatch #(.READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
        .i_clk                 (clk),
        .i_areset_n            (rst_n),
        .i_tx_packet_available (tx_avail),
        .o_tx_packet_read      (pkt_read),
        .i_tx_fifo_empty       (fifo_empty),
        .o_tx_fifo_rd_en       (rd_en),
        .i_tx_fifo_rd_data     (rd_data),
        .i_tx_bytes_last_word  (bytes_last),
        .io_mac_tx             (mac_if),
        .o_busy                (busy),
        .o_error               (error),
        .o_stat_packets        (stat_p),
        .o_stat_beats          (stat_b)
    );

    // Packet buffer model: address advances on rd_en, empty follows the
    // address a cycle later, data appears RL cycles after rd_en.
    logic [63:0] buf_mem [16];
    int          buf_nwords = 0;
    int          buf_addr = 0;
    logic        pkt_load;
    logic [63:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (pkt_load) buf_addr <= 0;
        else if (rd_en) buf_addr <= buf_addr + 1;
        rd_pipe[0] <= rd_en ? buf_mem[buf_addr % 16] : 64'hDEAD_DEAD_DEAD_DEAD;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign fifo_empty = (buf_addr >= buf_nwords);
    assign rd_data    = rd_pipe[RL-1];

    function automatic logic [63:0] word_of(input int tag, input int w);
        return {8'(tag), 8'(w), 16'hBEEF, 8'(tag * 7), 8'(w * 13 + 1), 16'hA5C3};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_packet(input int n, input logic [3:0] nb, input int tag);
        @(negedge clk);
        for (int w = 0; w < n; w++) buf_mem[w] = word_of(tag, w);
        buf_nwords = n;
        bytes_last = nb;
        pkt_load   = 1'b1;
        @(negedge clk);
        pkt_load   = 1'b0;
    endtask

    typedef struct {
        string      name;
        int         nwords;
        logic [3:0] nbytes;
        logic [3:0] rpat;      // ready pattern, bit (cycle % 4)
        logic [7:0] exp_keep;  // keep on the last beat
        int         exp_rd;
        int         exp_beats;
    } vec_t;

    vec_t vecs [6];

    task automatic run_packet(input string nm, input int n, input logic [3:0] nb,
                              input logic [3:0] rpat, input logic [7:0] exp_keep,
                              input int exp_rd, input int exp_beats, input int tag);
        int beats, rds, pulses, cyc, after;
        bit rel_due, hold_chk, exp_last;
        logic [63:0] held;
        load_packet(n, nb, tag);
        tx_avail = 1'b1;
        beats = 0; rds = 0; pulses = 0; cyc = 0; after = -1;
        rel_due = 0; hold_chk = 0; held = '0;
        while (after < 3 && cyc < 300) begin
            mac_if.ready = rpat[cyc % 4];
            if (rd_en) rds++;
            if (pkt_read) begin
                pulses++;
                if (after < 0) after = 0;
            end
            if (rel_due) begin
                chk({nm, "_release_timing"}, 64'(pkt_read), 64'd1);
                rel_due = 0;
            end
            if (hold_chk) begin
                chk({nm, "_hold_valid"}, 64'(mac_if.valid), 64'd1);
                chk({nm, "_hold_data"}, mac_if.data, held);
                hold_chk = 0;
            end
            if (mac_if.valid) begin
                if (mac_if.ready) begin
                    beats++;
                    exp_last = (beats == n);
                    chk({nm, "_data"}, mac_if.data, word_of(tag, beats - 1));
                    chk({nm, "_keep"}, 64'(mac_if.keep), exp_last ? 64'(exp_keep) : 64'hFF);
                    chk({nm, "_last"}, 64'(mac_if.last), 64'(exp_last));
                    if (mac_if.last) rel_due = 1;
                end else begin
                    held     = mac_if.data;
                    hold_chk = 1;
                end
            end
            @(negedge clk);
            cyc++;
            if (after >= 0) after++;
        end
        chk({nm, "_beats"}, 64'(beats), 64'(exp_beats));
        chk({nm, "_rd_en_count"}, 64'(rds), 64'(exp_rd));
        chk({nm, "_pkt_read_count"}, 64'(pulses), 64'd1);
        chk({nm, "_error"}, 64'(error), 64'd0);
        chk({nm, "_busy_wait"}, 64'(busy), 64'd1);
        tx_avail = 1'b0;
        repeat (2) @(negedge clk);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
        $display("pkt %s words=%0d beats=%0d rd=%0d pulses=%0d cycles=%0d", nm, n, beats, rds, pulses, cyc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, pulses, cyc;
        vecs[0] = '{"one_word_b5",   1, 4'd5, 4'b1111, 8'hF8, 1, 1};
        vecs[1] = '{"three_word_b8", 3, 4'd8, 4'b1111, 8'hFF, 3, 3};
        vecs[2] = '{"four_word_stall", 4, 4'd3, 4'b1001, 8'hE0, 4, 4};
        vecs[3] = '{"two_word_b0",   2, 4'd0, 4'b1111, 8'hFF, 2, 2};
        vecs[4] = '{"six_word_b1",   6, 4'd1, 4'b1010, 8'h80, 6, 6};
        vecs[5] = '{"two_word_b7",   2, 4'd7, 4'b0110, 8'hFE, 2, 2};

        rst_n = 1'b0; tx_avail = 1'b0; pkt_load = 1'b0; bytes_last = 4'd0;
        mac_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(mac_if.valid), 64'd0);
        chk("rst_data", mac_if.data, 64'd0);
        chk("rst_keep", 64'(mac_if.keep), 64'd0);
        chk("rst_last", 64'(mac_if.last), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_pkt_read", 64'(pkt_read), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_stat_packets", 64'(stat_p), 64'd0);
        chk("rst_stat_beats", 64'(stat_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_packet(vecs[i].name, vecs[i].nwords, vecs[i].nbytes, vecs[i].rpat,
                       vecs[i].exp_keep, vecs[i].exp_rd, vecs[i].exp_beats, i + 1);
        end

        // Zero-word packet: error, release pulse, no beats.
        load_packet(0, 4'd4, 20);
        mac_if.ready = 1'b1;
        tx_avail = 1'b1;
        @(negedge clk);
        chk("zero_pkt_read", 64'(pkt_read), 64'd1);
        chk("zero_error", 64'(error), 64'd1);
        chk("zero_valid", 64'(mac_if.valid), 64'd0);
        chk("zero_rd_en", 64'(rd_en), 64'd0);
        @(negedge clk);
        chk("zero_pkt_read_once", 64'(pkt_read), 64'd0);
        tx_avail = 1'b0;
        repeat (2) @(negedge clk);
        chk("zero_idle", 64'(busy), 64'd0);
        $display("pkt zero_word error=%0b", error);
        reset_pulse();
        chk("error_cleared", 64'(error), 64'd0);

        // Abort: available drops as beat 2 is accepted.
        load_packet(5, 4'd8, 30);
        mac_if.ready = 1'b1;
        tx_avail = 1'b1;
        beats = 0; pulses = 0; cyc = 0;
        while (beats < 2 && cyc < 100) begin
            if (pkt_read) pulses++;
            if (mac_if.valid && mac_if.ready) begin
                beats++;
                if (beats == 2) tx_avail = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("abort_beats_before", 64'(beats), 64'd2);
        chk("abort_error", 64'(error), 64'd1);
        chk("abort_valid", 64'(mac_if.valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (3) begin
            if (pkt_read) pulses++;
            @(negedge clk);
        end
        chk("abort_no_pkt_read", 64'(pulses), 64'd0);
        chk("abort_valid_stays", 64'(mac_if.valid), 64'd0);
        $display("pkt abort beats=%0d error=%0b", beats, error);
        reset_pulse();

        // Reset while draining two buffered words.
        load_packet(2, 4'd6, 40);
        mac_if.ready = 1'b0;
        tx_avail = 1'b1;
        cyc = 0;
        while (!mac_if.valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_valid", 64'(mac_if.valid), 64'd1);
        chk("drain_head", mac_if.data, word_of(40, 0));
        chk("drain_keep", 64'(mac_if.keep), 64'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(mac_if.valid), 64'd0);
        chk("midrst_data", mac_if.data, 64'd0);
        chk("midrst_keep", 64'(mac_if.keep), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        tx_avail = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("pkt reset_in_drain done");
        run_packet("after_reset", 3, 4'd4, 4'b1111, 8'hF0, 3, 3, 41);

        // Statistics over three packets of 2, 3 and 1 words.
        reset_pulse();
        run_packet("stat_a", 2, 4'd8, 4'b1111, 8'hFF, 2, 2, 50);
        run_packet("stat_b", 3, 4'd2, 4'b1101, 8'hC0, 3, 3, 51);
        run_packet("stat_c", 1, 4'd6, 4'b1111, 8'hFC, 1, 1, 52);
`ifdef NTS_TX_DISPATCH_COUNTERS_EN
        chk("stat_packets", 64'(stat_p), 64'd3);
        chk("stat_beats", 64'(stat_b), 64'd6);
`else
        chk("stat_packets", 64'(stat_p), 64'd0);
        chk("stat_beats", 64'(stat_b), 64'd0);
`endif
        $display("stats packets=%0d beats=%0d", stat_p, stat_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
